// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with
// optional two's-complement handling and a valid/ready handshake on each side.
module div_seq #(
    parameter int LEN    = 16,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [LEN-1:0] A,
    input  logic [LEN-1:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] Q,
    output logic [LEN-1:0] R,
    output logic           div_zero
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  cnt;
    logic [LEN-1:0] rem, quo, dvs, a_hold;
    logic           q_neg, r_neg, dz;

    logic           a_neg, b_neg;
    logic [LEN-1:0] a_mag, b_mag;
    logic [LEN:0]   shifted, diff;
    logic           ge;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Magnitudes are taken as unsigned LEN-bit values, so the most-negative
    // input maps onto 2^(LEN-1) without overflow.
    assign a_neg = (SIGNED != 0) && A[LEN-1];
    assign b_neg = (SIGNED != 0) && B[LEN-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // Partial remainder stays below the divisor, so LEN+1 bits hold the
    // shifted value and bit LEN of the difference is the borrow.
    assign shifted = {rem, quo[LEN-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = ~diff[LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = BUSY;
            BUSY:    if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            a_hold   <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt    <= '0;
                    rem    <= '0;
                    quo    <= a_mag;
                    dvs    <= b_mag;
                    a_hold <= A;
                    q_neg  <= a_neg ^ b_neg;
                    r_neg  <= a_neg;
                    dz     <= (B == '0);
                end
                BUSY: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                        rem <= ge ? diff[LEN-1:0] : shifted[LEN-1:0];
                        quo <= {quo[LEN-2:0], ge};
                    end else begin
                        // Divide-by-zero bypasses sign fix-up so R returns A verbatim.
                        Q        <= dz ? '1     : (q_neg ? -quo : quo);
                        R        <= dz ? a_hold : (r_neg ? -rem : rem);
                        div_zero <= dz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq (LEN=16), unsigned and signed
// instances run in lockstep on shared stimulus.
module tb_div_seq;

    logic        clk, rst_n, in_valid, out_ready;
    logic [15:0] a, b;
    logic        ir_u, ov_u, dz_u, ir_s, ov_s, dz_s;
    logic [15:0] q_u, r_u, q_s, r_s;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.LEN(16), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_u),
        .A(a), .B(b), .out_valid(ov_u), .out_ready(out_ready),
        .Q(q_u), .R(r_u), .div_zero(dz_u));

    div_seq #(.LEN(16), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
        .A(a), .B(b), .out_valid(ov_s), .out_ready(out_ready),
        .Q(q_s), .R(r_s), .div_zero(dz_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one operand pair, then scramble A/B every cycle until both
    // instances present a result. lat counts edges after the accept edge.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic rdy, output int lat);
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        lat = 0;
        while (!(ov_u && ov_s) && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            a = 16'($urandom); b = 16'($urandom);
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #3;
        n_checks++;
        if ({ir_u, ov_u, q_u, r_u, dz_u} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_u: got ir=%b ov=%b q=%h r=%h dz=%b", ir_u, ov_u, q_u, r_u, dz_u);
        end
        n_checks++;
        if ({ir_s, ov_s, q_s, r_s, dz_s} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_s: got ir=%b ov=%b q=%h r=%h dz=%b", ir_s, ov_s, q_s, r_s, dz_s);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(16'd100, 16'd7, 1'b1, lat);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        n_checks++;
        if ({q_u, r_u, dz_u} !== {16'd14, 16'd2, 1'b0}) begin
            n_fail++; $display("FAIL basic_u: got q=%0d r=%0d dz=%b expected 14 2 0", q_u, r_u, dz_u);
        end
        n_checks++;
        if ({q_s, r_s, dz_s} !== {16'd14, 16'd2, 1'b0}) begin
            n_fail++; $display("FAIL basic_s: got q=%0d r=%0d dz=%b expected 14 2 0", q_s, r_s, dz_s);
        end
        release_op();
        n_checks++;
        if ({ir_u, ov_u, ir_s, ov_s} !== 4'b1010) begin
            n_fail++; $display("FAIL basic_return_idle: got ir/ov %b expected 1010", {ir_u, ov_u, ir_s, ov_s});
        end
    endtask

    task automatic test_signed();
        int lat;
        do_op(16'hFFF9, 16'h0002, 1'b0, lat);
        n_checks++;
        if ({q_s, r_s, dz_s} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin
            n_fail++; $display("FAIL signed_neg_a: got q=%h r=%h dz=%b expected fffd ffff 0", q_s, r_s, dz_s);
        end
        n_checks++;
        if ({q_u, r_u} !== {16'h7FFC, 16'h0001}) begin
            n_fail++; $display("FAIL unsigned_fff9_2: got q=%h r=%h expected 7ffc 0001", q_u, r_u);
        end
        release_op();
        do_op(16'h0007, 16'hFFFE, 1'b0, lat);
        n_checks++;
        if ({q_s, r_s, dz_s} !== {16'hFFFD, 16'h0001, 1'b0}) begin
            n_fail++; $display("FAIL signed_neg_b: got q=%h r=%h dz=%b expected fffd 0001 0", q_s, r_s, dz_s);
        end
        n_checks++;
        if ({q_u, r_u} !== {16'h0000, 16'h0007}) begin
            n_fail++; $display("FAIL unsigned_7_fffe: got q=%h r=%h expected 0000 0007", q_u, r_u);
        end
        release_op();
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(16'h1234, 16'h0000, 1'b0, lat);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 17", lat); end
        n_checks++;
        if ({q_u, r_u, dz_u, q_s, r_s, dz_s} !== {16'hFFFF, 16'h1234, 1'b1, 16'hFFFF, 16'h1234, 1'b1}) begin
            n_fail++; $display("FAIL divzero_1234: got u=%h/%h/%b s=%h/%h/%b expected ffff/1234/1", q_u, r_u, dz_u, q_s, r_s, dz_s);
        end
        release_op();
        do_op(16'h8001, 16'h0000, 1'b0, lat);
        n_checks++;
        if ({q_s, r_s, dz_s} !== {16'hFFFF, 16'h8001, 1'b1}) begin
            n_fail++; $display("FAIL divzero_neg_s: got q=%h r=%h dz=%b expected ffff 8001 1", q_s, r_s, dz_s);
        end
        release_op();
    endtask

    task automatic test_overflow();
        int lat;
        do_op(16'h8000, 16'hFFFF, 1'b0, lat);
        n_checks++;
        if ({q_s, r_s, dz_s} !== {16'h8000, 16'h0000, 1'b0}) begin
            n_fail++; $display("FAIL overflow_s: got q=%h r=%h dz=%b expected 8000 0000 0", q_s, r_s, dz_s);
        end
        n_checks++;
        if ({q_u, r_u, dz_u} !== {16'h0000, 16'h8000, 1'b0}) begin
            n_fail++; $display("FAIL overflow_u: got q=%h r=%h dz=%b expected 0000 8000 0", q_u, r_u, dz_u);
        end
        release_op();
    endtask

    task automatic test_hold();
        int lat;
        do_op(16'd1000, 16'd33, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            n_checks++;
            if ({q_u, r_u, ov_u, ir_u, q_s, r_s, ov_s, ir_s} !==
                {16'd30, 16'd10, 1'b1, 1'b0, 16'd30, 16'd10, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL hold_cycle%0d: got u=%0d/%0d ov=%b ir=%b s=%0d/%0d expected 30/10 ov=1 ir=0",
                                   i, q_u, r_u, ov_u, ir_u, q_s, r_s);
            end
        end
        release_op();
        n_checks++;
        if ({ir_u, ov_u} !== 2'b10) begin
            n_fail++; $display("FAIL hold_release: got ir=%b ov=%b expected 1 0", ir_u, ov_u);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen;
        @(negedge clk);
        a = 16'd500; b = 16'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ir_u, ov_u, q_u, r_u, dz_u, ir_s, ov_s, q_s, r_s, dz_s} !==
            {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            n_fail++; $display("FAIL abort_async: got u ir=%b ov=%b q=%h r=%h s ir=%b ov=%b q=%h r=%h",
                               ir_u, ov_u, q_u, r_u, ir_s, ov_s, q_s, r_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ov_u || ov_s) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: got out_valid seen=%b expected 0", seen); end
        do_op(16'd9, 16'd3, 1'b0, lat);
        n_checks++;
        if ({lat, q_u, r_u, q_s, r_s} !== {32'd17, 16'd3, 16'd0, 16'd3, 16'd0}) begin
            n_fail++; $display("FAIL abort_next_op: got lat=%0d u=%0d/%0d s=%0d/%0d expected 17 3/0", lat, q_u, r_u, q_s, r_s);
        end
        release_op();
    endtask

    task automatic test_random();
        int lat, sa, sb, tq, tr;
        logic [15:0] av, bv, equ, eru, eqs, ers;
        logic        edz;
        for (int n = 0; n < 150; n++) begin
            av = 16'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
            if (n % 20 == 5) begin av = 16'h8000; bv = 16'hFFFF; end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(av, bv, 1'($urandom_range(0, 1)), lat);
            edz = (bv == 16'h0);
            if (edz) begin
                equ = 16'hFFFF; eru = av; eqs = 16'hFFFF; ers = av;
            end else begin
                equ = av / bv; eru = av % bv;
                sa = $signed(av); sb = $signed(bv);
                tq = sa / sb; tr = sa % sb;
                eqs = tq[15:0]; ers = tr[15:0];
            end
            n_checks++;
            if ({lat, q_u, r_u, dz_u} !== {32'd17, equ, eru, edz}) begin
                n_fail++; $display("FAIL rand_u %h/%h: got lat=%0d q=%h r=%h dz=%b expected 17 %h %h %b",
                                   av, bv, lat, q_u, r_u, dz_u, equ, eru, edz);
            end
            n_checks++;
            if ({q_s, r_s, dz_s} !== {eqs, ers, edz}) begin
                n_fail++; $display("FAIL rand_s %h/%h: got q=%h r=%h dz=%b expected %h %h %b",
                                   av, bv, q_s, r_s, dz_s, eqs, ers, edz);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_op();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_hold();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
